// File: rtl/controle_multiciclo.sv
// Multicycle MIPS-style control unit: 12-state FSM with a memory-wait watchdog.
// Define CONTROLE_ADDI_EN to enable the addi (opcode 001000) execute/writeback path.
module controle_multiciclo #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       IorD,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       ALUSrcA,
    output logic       PCEn,
    output logic       erro,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [2:0] ULAControl,
    output logic [3:0] estado
);

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StExecute = 4'd6,
        StAluWb   = 4'd7,
        StBranch  = 4'd8,
        StAddiEx  = 4'd9,
        StAddiWb  = 4'd10,
        StJump    = 4'd11
    } state_t;

    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpJ     = 6'b000010;
`ifdef CONTROLE_ADDI_EN
    localparam logic [5:0] OpAddi  = 6'b001000;
`endif

    localparam int unsigned  CntW   = (MEM_TIMEOUT > 15) ? $clog2(MEM_TIMEOUT + 1) : 4;
    localparam logic [CntW-1:0] CntMax = CntW'(MEM_TIMEOUT);

    state_t          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            waiting;
    logic            timeout;

    assign estado  = state_q;
    assign waiting = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
    assign timeout = (MEM_TIMEOUT != 0) && waiting && !mem_ready && (cnt_q == CntMax);

    // The counter is nonzero only while stalled in a wait state; every exit clears it,
    // so each entry into FETCH/MEMRD/MEMWR starts from zero. It saturates when timeout is off.
    always_comb begin
        if (waiting && !mem_ready && !timeout) begin
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        end else begin
            cnt_d = '0;
        end
    end

    always_comb begin
        IorD       = 1'b0;
        IRWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        ALUSrcA    = 1'b0;
        PCEn       = 1'b0;
        erro       = 1'b0;
        ALUSrcB    = 2'b00;
        PCSrc      = 2'b00;
        ULAControl = 3'b010;
        state_d    = StFetch;

        case (state_q)
            StFetch: begin
                ALUSrcB = 2'b01;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCEn    = 1'b1;
                    state_d = StDecode;
                end else begin
                    erro    = timeout;
                    state_d = StFetch;
                end
            end
            StDecode: begin
                ALUSrcB = 2'b11;
                case (opcode)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpRtype:    state_d = StExecute;
                    OpBeq:      state_d = StBranch;
`ifdef CONTROLE_ADDI_EN
                    OpAddi:     state_d = StAddiEx;
`endif
                    OpJ:        state_d = StJump;
                    default: begin
                        erro    = 1'b1;
                        state_d = StFetch;
                    end
                endcase
            end
            StMemAdr: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                if (opcode == OpLw) begin
                    state_d = StMemRd;
                end else if (opcode == OpSw) begin
                    state_d = StMemWr;
                end else begin
                    state_d = StFetch;
                end
            end
            StMemRd: begin
                IorD = 1'b1;
                if (mem_ready) begin
                    state_d = StMemWb;
                end else if (timeout) begin
                    erro    = 1'b1;
                    state_d = StFetch;
                end else begin
                    state_d = StMemRd;
                end
            end
            StMemWb: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
                state_d  = StFetch;
            end
            StMemWr: begin
                IorD = 1'b1;
                if (mem_ready) begin
                    MemWrite = 1'b1;
                    state_d  = StFetch;
                end else if (timeout) begin
                    erro    = 1'b1;
                    state_d = StFetch;
                end else begin
                    MemWrite = 1'b1;
                    state_d  = StMemWr;
                end
            end
            StExecute: begin
                ALUSrcA = 1'b1;
                state_d = StAluWb;
                case (funct)
                    6'b100100: ULAControl = 3'b000;
                    6'b100101: ULAControl = 3'b001;
                    6'b100000: ULAControl = 3'b010;
                    6'b100111: ULAControl = 3'b011;
                    6'b100010: ULAControl = 3'b110;
                    6'b101010: ULAControl = 3'b111;
                    default: begin
                        erro    = 1'b1;
                        state_d = StFetch;
                    end
                endcase
            end
            StAluWb: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
                state_d  = StFetch;
            end
            StBranch: begin
                ALUSrcA    = 1'b1;
                ULAControl = 3'b110;
                PCSrc      = 2'b01;
                PCEn       = Zero;
                state_d    = StFetch;
            end
`ifdef CONTROLE_ADDI_EN
            StAddiEx: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = StAddiWb;
            end
            StAddiWb: begin
                RegWrite = 1'b1;
                state_d  = StFetch;
            end
`endif
            StJump: begin
                PCSrc   = 2'b10;
                PCEn    = 1'b1;
                state_d = StFetch;
            end
            default: state_d = StFetch;
        endcase

        // Reset is asynchronous, so enables must drop before any clock edge arrives.
        if (!rst_n) begin
            IRWrite  = 1'b0;
            PCEn     = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            erro     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: doc/controle_multiciclo.md
CONTROLE_MULTICICLO -- requirements
Module: controle_multiciclo

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15, SHALL be the maximum memory-wait cycles per access; 0 SHALL disable the timeout.
REQ-002 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 opcode  input  6  SHALL be the instruction opcode field, instr[31:26].
REQ-005 funct  input  6  SHALL be the R-type function field, instr[5:0].
REQ-006 Zero  input  1  SHALL be the ALU Z flag.
REQ-007 mem_ready  input  1  SHALL be the memory-access-complete strobe.
REQ-008 Outputs, each 1 bit: IorD, IRWrite, MemWrite, RegWrite, RegDst, MemtoReg, ALUSrcA, PCEn, erro.
REQ-009 Outputs ALUSrcB and PCSrc SHALL each be 2 bits.
REQ-010 Output ULAControl (3) SHALL drive the ALU; output estado (4) SHALL expose the current state.

Function
REQ-011 States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11; unlisted encodings SHALL go to FETCH.
REQ-012 Any output not listed for a state SHALL be 0, except ULAControl, which SHALL default to 010 (add).
REQ-013 FETCH: ALUSrcB=01, ULAControl=010; IRWrite=PCEn=mem_ready. Stay while mem_ready=0; go to DECODE when mem_ready=1.
REQ-014 DECODE: ALUSrcB=11, add. Next state by opcode: 100011/101011 -> MEMADR, 000000 -> EXECUTE, 000100 -> BRANCH, 001000 -> ADDIEX, 000010 -> JUMP.
REQ-015 DECODE with any other opcode SHALL go to FETCH and pulse erro for 1 cycle.
REQ-016 MEMADR: ALUSrcA=1, ALUSrcB=10, add; next is MEMRD (lw) or MEMWR (sw).
REQ-017 MEMRD: IorD=1; stay until mem_ready=1, then go to MEMWB.
REQ-018 MEMWB: MemtoReg=1, RegWrite=1; next is FETCH.
REQ-019 MEMWR: IorD=1, MemWrite=1 held until mem_ready=1, then go to FETCH.
REQ-020 EXECUTE: ALUSrcA=1, ALUSrcB=00; funct decode 100100->000, 100101->001, 100000->010, 100111->011, 100010->110, 101010->111; next is ALUWB.
REQ-021 EXECUTE with any other funct SHALL use ULAControl=010, pulse erro, and go to FETCH with no writeback.
REQ-022 ALUWB: RegDst=1, RegWrite=1; next is FETCH.
REQ-023 BRANCH: ALUSrcA=1, ULAControl=110, PCSrc=01, PCEn=Zero (same cycle); next is FETCH.
REQ-024 ADDIEX: ALUSrcA=1, ALUSrcB=10, add; next is ADDIWB. ADDIWB: RegWrite=1; next is FETCH.
REQ-025 JUMP: PCSrc=10, PCEn=1; next is FETCH.
REQ-026 Wait counter (4-bit minimum) SHALL clear on entering FETCH, MEMRD or MEMWR, and SHALL increment each cycle spent waiting there with mem_ready=0.
REQ-027 When the wait counter reaches MEM_TIMEOUT (>0) with mem_ready still 0: erro=1 that cycle, all write enables 0, next state FETCH.
REQ-028 If mem_ready=1 on the timeout cycle, the access SHALL complete normally with no erro.
REQ-029 Every instruction SHALL end in FETCH. Latency: lw 5, sw 4, R 4, beq 3, addi 4, j 3 cycles, each with zero memory wait.

Reset
REQ-030 rst_n=0 SHALL immediately force estado=FETCH, counter=0 and erro=0.
REQ-031 During rst_n=0, IRWrite, PCEn, MemWrite and RegWrite SHALL be 0 regardless of mem_ready.
REQ-032 Reset mid-instruction SHALL abandon the instruction; no partial writeback after release.

Configuration
REQ-033 With macro CONTROLE_ADDI_EN defined, opcode 001000 SHALL take the ADDIEX/ADDIWB path.
REQ-034 Without CONTROLE_ADDI_EN, opcode 001000 SHALL be illegal (REQ-015), and states 9/10 SHALL be unreachable and treated as unlisted.

Verification
REQ-035 Reset, then R-type add (opcode 0, funct 100000), mem_ready=1 -> estado 0,1,6,7,0; ULAControl=010 in EXECUTE; RegWrite=1, RegDst=1 in ALUWB only.
REQ-036 lw with mem_ready low for 3 cycles in MEMRD -> MEMRD held 4 cycles; MemtoReg=RegWrite=1 in exactly one cycle; no erro.
REQ-037 beq with Zero=1 -> PCEn=1, PCSrc=01 in BRANCH; repeat with Zero=0 -> PCEn=0.
REQ-038 MEM_TIMEOUT=3, mem_ready held 0 in FETCH -> erro pulses on the 4th wait cycle; IRWrite never asserted; estado stays 0.
REQ-039 Opcode 111111 -> erro=1 for one cycle after DECODE, no write enable asserted; opcode 001000 -> illegal without CONTROLE_ADDI_EN, 4-cycle addi with it.
REQ-040 rst_n low during MEMWR (MemWrite=1) -> MemWrite drops asynchronously; estado=0 before the next clock edge.
